// File: rtl/reg_writeback_queue.sv
// In-order writeback FIFO that drains one entry per cycle into the register file, with decode-side forwarding under `WB_FORWARD_EN.
// An accepted write reaches the write port the next cycle at the earliest; wb_ready is low only when full, and hold stalls the drain.
module reg_writeback_queue #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wb_valid,
   input  logic [4:0]               wb_addr,
   input  logic [31:0]              wb_data,
   output logic                     wb_ready,
   input  logic                     hold,
   output logic [4:0]               write_addr,
   output logic [31:0]              write_data,
   output logic                     reg_write,
   input  logic [4:0]               fwd_addr_1,
   input  logic [4:0]               fwd_addr_2,
   output logic                     fwd_hit_1,
   output logic                     fwd_hit_2,
   output logic [31:0]              fwd_data_1,
   output logic [31:0]              fwd_data_2,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [4:0]    addr_q [DEPTH];
   logic [31:0]   data_q [DEPTH];
   logic [AW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic          push, pop;

   assign wb_ready = (count_q < FULL);
   // Writes to $0 complete the handshake but are dropped here.
   assign push     = wb_valid && wb_ready && (wb_addr != 5'd0);
   assign pop      = (count_q != '0) && !hold;

   assign reg_write  = pop;
   assign write_addr = (count_q != '0) ? addr_q[head_q] : 5'd0;
   assign write_data = (count_q != '0) ? data_q[head_q] : 32'd0;
   assign count      = count_q;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (push) tail_d = tail_q + AW'(1);
      if (pop)  head_d = head_q + AW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[tail_q] <= wb_addr;
         data_q[tail_q] <= wb_data;
      end
   end

`ifdef WB_FORWARD_EN
   logic [AW-1:0] idx;
   logic          hit1, hit2;
   logic [31:0]   dat1, dat2;

   // Walk entries oldest to newest so the newest match overwrites older ones.
   always_comb begin
      idx  = head_q;
      hit1 = 1'b0;
      hit2 = 1'b0;
      dat1 = 32'd0;
      dat2 = 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head_q + AW'(i);
         if (CW'(i) < count_q) begin
            if (addr_q[idx] == fwd_addr_1) begin
               hit1 = 1'b1;
               dat1 = data_q[idx];
            end
            if (addr_q[idx] == fwd_addr_2) begin
               hit2 = 1'b1;
               dat2 = data_q[idx];
            end
         end
      end
   end

   assign fwd_hit_1  = hit1 && (fwd_addr_1 != 5'd0);
   assign fwd_hit_2  = hit2 && (fwd_addr_2 != 5'd0);
   assign fwd_data_1 = fwd_hit_1 ? dat1 : 32'd0;
   assign fwd_data_2 = fwd_hit_2 ? dat2 : 32'd0;
`else
   logic unused_fwd;
   assign unused_fwd = ^{fwd_addr_1, fwd_addr_2};
   assign fwd_hit_1  = 1'b0;
   assign fwd_hit_2  = 1'b0;
   assign fwd_data_1 = 32'd0;
   assign fwd_data_2 = 32'd0;
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench for reg_writeback_queue at DEPTH=4; forwarding expectations follow WB_FORWARD_EN.
module tb_reg_writeback_queue;
   localparam bit FWD_ON =
`ifdef WB_FORWARD_EN
      1'b1;
`else
      1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        wb_valid = 1'b0;
   logic [4:0]  wb_addr = '0;
   logic [31:0] wb_data = '0;
   logic        wb_ready;
   logic        hold = 1'b0;
   logic [4:0]  write_addr;
   logic [31:0] write_data;
   logic        reg_write;
   logic [4:0]  fwd_addr_1 = '0, fwd_addr_2 = '0;
   logic        fwd_hit_1, fwd_hit_2;
   logic [31:0] fwd_data_1, fwd_data_2;
   logic [2:0]  count;

   int checks = 0;
   int errors = 0;

   reg_writeback_queue #(.DEPTH(4)) dut (
      .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
      .wb_ready(wb_ready), .hold(hold), .write_addr(write_addr), .write_data(write_data),
      .reg_write(reg_write), .fwd_addr_1(fwd_addr_1), .fwd_addr_2(fwd_addr_2),
      .fwd_hit_1(fwd_hit_1), .fwd_hit_2(fwd_hit_2), .fwd_data_1(fwd_data_1),
      .fwd_data_2(fwd_data_2), .count(count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1;
      checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL reset_reg_write got %0b want 0", reg_write); end
      checks++; if (write_addr !== 5'd0) begin errors++; $display("FAIL reset_write_addr got %0d want 0", write_addr); end
      checks++; if (write_data !== 32'd0) begin errors++; $display("FAIL reset_write_data got %h want 0", write_data); end
      checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL reset_wb_ready got %0b want 1", wb_ready); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
      checks++; if (fwd_hit_1 !== 1'b0 || fwd_data_1 !== 32'd0) begin errors++; $display("FAIL reset_fwd got %0b/%h want 0/0", fwd_hit_1, fwd_data_1); end
      #3 reset = 1'b0;
      step();
   endtask

   task automatic test_single_write();
      wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
      step();
      wb_valid = 1'b0;
      checks++; if (reg_write !== 1'b1) begin errors++; $display("FAIL single_reg_write got %0b want 1", reg_write); end
      checks++; if (write_addr !== 5'd5) begin errors++; $display("FAIL single_addr got %0d want 5", write_addr); end
      checks++; if (write_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data got %h want deadbeef", write_data); end
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count got %0d want 1", count); end
      step();
      checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL single_after_reg_write got %0b want 0", reg_write); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_after_count got %0d want 0", count); end
   endtask

   task automatic test_fill();
      hold = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         wb_valid = 1'b1; wb_addr = 5'(i); wb_data = 32'h100 + 32'(i);
         step();
      end
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d want 4", count); end
      checks++; if (wb_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got %0b want 0", wb_ready); end
      checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL fill_hold_reg_write got %0b want 0", reg_write); end
      wb_addr = 5'd9; wb_data = 32'h999;
      step();
      wb_valid = 1'b0;
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_fifth_count got %0d want 4", count); end
      hold = 1'b0;
      #1;
      for (int i = 1; i <= 4; i++) begin
         checks++; if (reg_write !== 1'b1 || write_addr !== 5'(i) || write_data !== 32'h100 + 32'(i)) begin
            errors++; $display("FAIL fill_drain_%0d got we=%0b a=%0d d=%h want 1/%0d/%h", i, reg_write, write_addr, write_data, i, 32'h100 + 32'(i));
         end
         if (i == 1) begin
            checks++; if (wb_ready !== 1'b0) begin errors++; $display("FAIL fill_ready_during_drain got %0b want 0", wb_ready); end
         end
         step();
         checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_after_%0d got %0b want 1", i, wb_ready); end
      end
      hold = 1'b1;
      #1;
      checks++; if (count !== 3'd0 || reg_write !== 1'b0) begin errors++; $display("FAIL fill_empty got c=%0d we=%0b want 0/0", count, reg_write); end
      hold = 1'b0;
   endtask

   task automatic test_forward();
      hold = 1'b1;
      wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h11;
      step();
      wb_data = 32'h22;
      step();
      wb_addr = 5'd8; wb_data = 32'h88;
      fwd_addr_1 = 5'd7; fwd_addr_2 = 5'd8;
      #1;
      checks++; if (fwd_hit_1 !== FWD_ON) begin errors++; $display("FAIL fwd_hit_1 got %0b want %0b", fwd_hit_1, FWD_ON); end
      checks++; if (fwd_data_1 !== (FWD_ON ? 32'h22 : 32'h0)) begin errors++; $display("FAIL fwd_data_1 got %h want %h", fwd_data_1, FWD_ON ? 32'h22 : 32'h0); end
      checks++; if (fwd_hit_2 !== 1'b0 || fwd_data_2 !== 32'd0) begin errors++; $display("FAIL fwd_miss_2 got %0b/%h want 0/0", fwd_hit_2, fwd_data_2); end
      wb_valid = 1'b0;
      hold = 1'b0;
      #1;
      checks++; if (fwd_hit_1 !== FWD_ON || reg_write !== 1'b1 || write_data !== 32'h11) begin
         errors++; $display("FAIL fwd_head_drain got hit=%0b we=%0b d=%h want %0b/1/11", fwd_hit_1, reg_write, write_data, FWD_ON);
      end
      step();
      checks++; if (fwd_data_1 !== (FWD_ON ? 32'h22 : 32'h0) || write_data !== 32'h22 || count !== 3'd1) begin
         errors++; $display("FAIL fwd_second got fd=%h d=%h c=%0d want %h/22/1", fwd_data_1, write_data, count, FWD_ON ? 32'h22 : 32'h0);
      end
      step();
      checks++; if (fwd_hit_1 !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL fwd_after_commit got hit=%0b c=%0d want 0/0", fwd_hit_1, count); end
   endtask

   task automatic test_zero_filter();
      wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
      fwd_addr_1 = 5'd0;
      #1;
      checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL zero_ready got %0b want 1", wb_ready); end
      step();
      wb_valid = 1'b0;
      checks++; if (count !== 3'd0 || reg_write !== 1'b0) begin errors++; $display("FAIL zero_not_stored got c=%0d we=%0b want 0/0", count, reg_write); end
      checks++; if (fwd_hit_1 !== 1'b0) begin errors++; $display("FAIL zero_fwd got %0b want 0", fwd_hit_1); end
      step();
      checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL zero_later_reg_write got %0b want 0", reg_write); end
   endtask

   task automatic test_back_to_back();
      hold = 1'b1;
      for (int k = 0; k < 2; k++) begin
         wb_valid = 1'b1; wb_addr = 5'(10 + k); wb_data = 32'hA000 + 32'(k);
         step();
      end
      hold = 1'b0;
      for (int k = 2; k < 10; k++) begin
         wb_addr = 5'(10 + k); wb_data = 32'hA000 + 32'(k);
         #1;
         checks++; if (count !== 3'd2 || reg_write !== 1'b1 || write_addr !== 5'(10 + k - 2) || write_data !== 32'hA000 + 32'(k - 2)) begin
            errors++; $display("FAIL b2b_%0d got c=%0d we=%0b a=%0d d=%h want 2/1/%0d/%h", k, count, reg_write, write_addr, write_data, 10 + k - 2, 32'hA000 + 32'(k - 2));
         end
         step();
      end
      wb_valid = 1'b0;
      for (int k = 8; k < 10; k++) begin
         checks++; if (reg_write !== 1'b1 || write_addr !== 5'(10 + k) || write_data !== 32'hA000 + 32'(k)) begin
            errors++; $display("FAIL b2b_tail_%0d got we=%0b a=%0d d=%h want 1/%0d/%h", k, reg_write, write_addr, write_data, 10 + k, 32'hA000 + 32'(k));
         end
         step();
      end
      checks++; if (count !== 3'd0 || reg_write !== 1'b0) begin errors++; $display("FAIL b2b_empty got c=%0d we=%0b want 0/0", count, reg_write); end
   endtask

   task automatic test_reset_mid();
      hold = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wb_valid = 1'b1; wb_addr = 5'(20 + k); wb_data = 32'hB000 + 32'(k);
         step();
      end
      wb_valid = 1'b0;
      fwd_addr_1 = 5'd20;
      checks++; if (count !== 3'd3) begin errors++; $display("FAIL mid_pre_count got %0d want 3", count); end
      hold = 1'b0;
      #1 reset = 1'b1;
      #1;
      checks++; if (reg_write !== 1'b0 || count !== 3'd0 || wb_ready !== 1'b1) begin
         errors++; $display("FAIL mid_reset got we=%0b c=%0d rdy=%0b want 0/0/1", reg_write, count, wb_ready);
      end
      checks++; if (write_addr !== 5'd0 || fwd_hit_1 !== 1'b0) begin errors++; $display("FAIL mid_reset_outs got a=%0d hit=%0b want 0/0", write_addr, fwd_hit_1); end
      #1 reset = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL mid_post_%0d got we=%0b want 0", k, reg_write); end
      end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_fill();
      test_forward();
      test_zero_filter();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/reg_writeback_queue.md
# reg_writeback_queue

Write-side companion to the 32×32 register file: buffers register writebacks from the execute/memory stages in a small in-order FIFO and drains them, one per cycle, into the register file's single write port (`write_addr`, `write_data`, `reg_write`). It also gives the decode stage a forwarding lookup, so reads of a register with a queued, not-yet-committed write return the pending value. It sits between the writeback mux and the register file.

## Interface
- `DEPTH`, default 4: number of queue entries; must be a power of two, 2..16.
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; clears the queue.
- `wb_valid` input 1: upstream offers a writeback this cycle.
- `wb_addr` input 5: destination register of the offered writeback.
- `wb_data` input 32: data of the offered writeback.
- `wb_ready` output 1: the queue can accept a writeback this cycle.
- `hold` input 1: when 1, suppresses draining this cycle.
- `write_addr` output 5: to the register file's `write_addr`.
- `write_data` output 32: to the register file's `write_data`.
- `reg_write` output 1: to the register file's `reg_write`.
- `fwd_addr_1`, `fwd_addr_2` input 5 each: register file read addresses being looked up.
- `fwd_hit_1`, `fwd_hit_2` output 1 each: a queued write to that address exists.
- `fwd_data_1`, `fwd_data_2` output 32 each: data of the newest matching queued write.
- `count` output log2(DEPTH)+1: number of occupied entries.

## Operation
- Storage: circular buffer of {addr[4:0], data[31:0]} with head pointer, tail pointer and occupancy count. Both pointers wrap modulo DEPTH.
- Accept: `wb_ready = (count < DEPTH)`. It does not depend on `wb_valid` or on a drain in the same cycle.
- Enqueue: on a rising edge with `wb_valid && wb_ready`, write {`wb_addr`, `wb_data`} at the tail, then advance the tail.
- `$0` filter: a writeback with `wb_addr == 0` is accepted (handshake completes) but is not stored. Count and tail are unchanged.
- Drain: `reg_write = (count != 0) && !hold`. `write_addr` and `write_data` are the head entry when count is not 0, and 0 when it is. On a rising edge with `reg_write == 1`, advance the head.
- Enqueue and drain in the same edge: count is unchanged and both pointers advance.
- Order: commits happen strictly in acceptance order, so a later write to the same register always overwrites an earlier one.
- Forwarding, per port n:
  - Compare `fwd_addr_n` against every occupied entry, including the head being drained this cycle.
  - `fwd_hit_n = 1` if any entry matches and `fwd_addr_n != 0`.
  - `fwd_data_n` = data of the matching entry closest to the tail (newest); 0 when there is no hit.
  - A writeback on `wb_*` that has not yet been accepted is never forwarded.
- Reset, asynchronous:
  - Head, tail and count go to 0, discarding any pending entries.
  - Immediate output values: `reg_write = 0`, `write_addr = 0`, `write_data = 0`, `wb_ready = 1`, `fwd_hit_* = 0`, `fwd_data_* = 0`, `count = 0`.
  - Entry storage itself need not be cleared.

## Timing
- All outputs are combinational from registered state, except `fwd_*`, which also depend on `fwd_addr_*`. There is no input-to-output path from `wb_*`.
- Latency: a writeback accepted at edge k is presented on the write port starting in the cycle after edge k, at the earliest. It commits at the first edge after that with `hold == 0` and all older entries drained.
- The register file sees the data at the commit edge. From the next cycle its read returns the new value, and that entry's forwarding hit ends at the same edge, leaving no gap.
- Full: with count == DEPTH, `wb_ready = 0` even if a drain occurs that cycle. Ready returns the cycle after the drain.
- Empty: with count == 0, no drain occurs regardless of `hold`. A write accepted that edge is visible on the write port the next cycle.
- Holding `hold` indefinitely keeps the head stable, with `reg_write = 0`.

## Configuration
- `WB_FORWARD_EN`: when defined, the forwarding comparators and newest-match selection are compiled in as described above.
- When undefined, `fwd_hit_1`, `fwd_hit_2`, `fwd_data_1` and `fwd_data_2` are tied to 0. The ports remain, and the queue behaviour is identical.

## Test plan
- Reset then single write: reset, then offer `wb_addr=5`, `wb_data=0xDEADBEEF` for one cycle.
  - Next cycle: `reg_write=1`, `write_addr=5`, `write_data=0xDEADBEEF`, `count=1`.
  - Following cycle: `reg_write=0`, `count=0`.
- Fill and back-pressure: `hold=1` and DEPTH=4; accept writes to r1..r4.
  - `wb_ready=0` with `count=4`, and a fifth offer is not accepted.
  - Release `hold`: r1..r4 commit in order on 4 consecutive edges, and `wb_ready=1` from the cycle after the first commit.
- Forward newest: with `hold=1`, queue r7←0x11 then r7←0x22.
  - `fwd_addr_1=7` gives `fwd_hit_1=1`, `fwd_data_1=0x22`.
  - `fwd_addr_2=8` gives `fwd_hit_2=0`, `fwd_data_2=0`.
- `$0` filter: offer `wb_addr=0`, `wb_data=0xFFFFFFFF`.
  - `wb_ready=1` and `count` stays 0; `reg_write` never asserts.
  - `fwd_addr_1=0` gives `fwd_hit_1=0`.
- Simultaneous enqueue and drain: with `count=2`, accept a write while draining.
  - `count` stays 2, and commit order matches acceptance order across pointer wrap (run 10 writes at DEPTH=4).
- Reset mid-operation: assert `reset` between edges with `count=3`.
  - Immediately `reg_write=0`, `count=0`, `wb_ready=1`.
  - No queued entry is ever written after reset is released.
